// File: rtl/store_ctrl_banked.sv
// Banked multi-core store controller: per-core staging banks that are flushed to memory
// as a burst of concatenated beats once every enabled core has reached the store barrier.
module store_ctrl_banked #(
  parameter int NCORES = 4,
  parameter int DW     = 16,
  parameter int DEPTH  = 16,
  parameter int AW     = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NCORES-1:0]              op,
  input  logic [NCORES*$clog2(DEPTH)-1:0] reg_addr,
  input  logic [NCORES*DW-1:0]           wr_data,
  input  logic [NCORES-1:0]              wr_en,
  input  logic [NCORES-1:0]              core_mask,
  input  logic [AW-1:0]                  base_addr,
  input  logic                           mem_ready,
  output logic                           mem_wr,
  output logic [AW-1:0]                  mem_addr,
  output logic [NCORES*DW-1:0]           mem_wdata,
  output logic                           busy,
  output logic                           done,
  output logic [NCORES-1:0]              wr_err
);
  localparam int IW = $clog2(DEPTH);

  typedef enum logic {IDLE, BURST} state_t;
  state_t state, state_nx;

  logic [DW-1:0]                  bank [NCORES][DEPTH];
  logic [NCORES-1:0][DEPTH-1:0]   valid;
  logic [NCORES-1:0]              op_seen;
  logic [IW-1:0]                  hwm;
  logic [IW-1:0]                  last;
  logic [IW-1:0]                  beat;
  logic                           written;
  logic [AW-1:0]                  base_l;
  logic [IW-1:0]                  wr_max;
  logic                           any_wr;
  logic                           fire;
  logic                           accept;
  logic                           last_beat;

  // High-water mark including writes landing on this edge, so a write that
  // coincides with the final op is part of the burst.
  always_comb begin
    wr_max = hwm;
    for (int i = 0; i < NCORES; i++) begin
      if (wr_en[i] && (reg_addr[i*IW +: IW] > wr_max)) wr_max = reg_addr[i*IW +: IW];
    end
  end

  assign any_wr    = |wr_en;
  assign fire      = (state == IDLE) && (core_mask != '0) &&
                     (((op_seen | op) & core_mask) == core_mask);
  assign accept    = (state == BURST) && mem_ready;
  assign last_beat = (beat == last);

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (fire && (written || any_wr)) state_nx = BURST;
      BURST:   if (accept && last_beat)         state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      valid   <= '0;
      op_seen <= '0;
      hwm     <= '0;
      written <= 1'b0;
      beat    <= '0;
      done    <= 1'b0;
      wr_err  <= '0;
    end else begin
      state  <= state_nx;
      done   <= 1'b0;
      wr_err <= '0;
      if (state == IDLE) begin
        for (int i = 0; i < NCORES; i++) begin
          if (wr_en[i]) valid[i][reg_addr[i*IW +: IW]] <= 1'b1;
        end
        hwm     <= wr_max;
        written <= written | any_wr;
        op_seen <= op_seen | op;
        if (fire) begin
          op_seen <= '0;
          beat    <= '0;
          // Barrier with nothing staged completes immediately without a burst.
          if (!(written || any_wr)) begin
            done    <= 1'b1;
            hwm     <= '0;
            written <= 1'b0;
          end
        end
      end else begin
        wr_err <= wr_en;
        if (accept) begin
          if (last_beat) begin
            done    <= 1'b1;
            valid   <= '0;
            hwm     <= '0;
            written <= 1'b0;
          end else begin
            beat <= beat + IW'(1);
          end
        end
      end
    end
  end

  // Bank contents and burst parameters carry no reset; they are qualified by valid/state.
  always_ff @(posedge clk) begin
    if (state == IDLE) begin
      for (int i = 0; i < NCORES; i++) begin
        if (wr_en[i]) bank[i][reg_addr[i*IW +: IW]] <= wr_data[i*DW +: DW];
      end
      if (fire) begin
        base_l <= base_addr;
        last   <= wr_max;
      end
    end
  end

  assign mem_wr   = (state == BURST);
  assign busy     = (state == BURST);
  assign mem_addr = (state == BURST) ? (base_l + AW'(beat)) : '0;

  always_comb begin
    mem_wdata = '0;
    if (state == BURST) begin
      for (int i = 0; i < NCORES; i++) begin
        if (valid[i][beat]) mem_wdata[i*DW +: DW] = bank[i][beat];
      end
    end
  end
endmodule

// File: tb/tb_store_ctrl_banked.sv
// Bench for store_ctrl_banked: directed scenarios plus random traffic, checked every cycle
// against a queue-of-expected-beats model of the store behaviour.
module tb_store_ctrl_banked;
  localparam int NCORES = 4;
  localparam int DW     = 16;
  localparam int DEPTH  = 16;
  localparam int AW     = 16;
  localparam int IW     = 4;
  localparam int MW     = NCORES*DW;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NCORES-1:0] op = '0;
  logic [NCORES*IW-1:0] reg_addr = '0;
  logic [MW-1:0]     wr_data = '0;
  logic [NCORES-1:0] wr_en = '0;
  logic [NCORES-1:0] core_mask = '0;
  logic [AW-1:0]     base_addr = '0;
  logic              mem_ready = 1'b0;
  logic              mem_wr;
  logic [AW-1:0]     mem_addr;
  logic [MW-1:0]     mem_wdata;
  logic              busy;
  logic              done;
  logic [NCORES-1:0] wr_err;

  always #5 clk = ~clk;

  store_ctrl_banked #(.NCORES(NCORES), .DW(DW), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .reg_addr(reg_addr), .wr_data(wr_data),
    .wr_en(wr_en), .core_mask(core_mask), .base_addr(base_addr), .mem_ready(mem_ready),
    .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .busy(busy),
    .done(done), .wr_err(wr_err)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference model: shadow banks, sticky ops, and a queue of beats still owed to memory.
  typedef struct {
    logic [AW-1:0] addr;
    logic [MW-1:0] data;
  } beat_t;

  beat_t             q[$];
  logic [DW-1:0]     sh_bank [NCORES][DEPTH];
  bit                sh_val  [NCORES][DEPTH];
  logic [NCORES-1:0] m_seen;
  logic              exp_done;
  logic [NCORES-1:0] exp_err;

  always @(posedge clk or negedge rst_n) begin
    int    top;
    beat_t b;
    if (!rst_n) begin
      q.delete();
      m_seen   = '0;
      exp_done = 1'b0;
      exp_err  = '0;
      foreach (sh_val[i, j]) sh_val[i][j] = 1'b0;
    end else begin
      exp_done = 1'b0;
      exp_err  = '0;
      if (q.size() > 0) begin
        exp_err = wr_en;
        if (mem_ready) begin
          void'(q.pop_front());
          if (q.size() == 0) begin
            exp_done = 1'b1;
            foreach (sh_val[i, j]) sh_val[i][j] = 1'b0;
          end
        end
      end else begin
        for (int i = 0; i < NCORES; i++) begin
          if (wr_en[i]) begin
            sh_bank[i][reg_addr[i*IW +: IW]] = wr_data[i*DW +: DW];
            sh_val[i][reg_addr[i*IW +: IW]]  = 1'b1;
          end
        end
        m_seen = m_seen | op;
        if (core_mask != '0 && (m_seen & core_mask) == core_mask) begin
          m_seen = '0;
          top = -1;
          foreach (sh_val[i, j]) if (sh_val[i][j] && j > top) top = j;
          if (top < 0) exp_done = 1'b1;
          for (int k = 0; k <= top; k++) begin
            b.addr = base_addr + AW'(k);
            b.data = '0;
            for (int i = 0; i < NCORES; i++)
              if (sh_val[i][k]) b.data[i*DW +: DW] = sh_bank[i][k];
            q.push_back(b);
          end
        end
      end
    end
  end

  logic [AW-1:0] log_addr[$];
  logic [MW-1:0] log_data[$];

  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_mem_wr", mem_wr, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_wr_err", wr_err, 0);
      check("rst_mem_addr", mem_addr, 0);
      check("rst_mem_wdata", mem_wdata, 0);
    end else begin
      check("mem_wr", mem_wr, q.size() > 0);
      check("busy", busy, q.size() > 0);
      check("done", done, exp_done);
      check("wr_err", wr_err, exp_err);
      if (q.size() > 0) begin
        check("mem_addr", mem_addr, q[0].addr);
        check("mem_wdata", mem_wdata, q[0].data);
      end
      if (mem_wr && mem_ready) begin
        log_addr.push_back(mem_addr);
        log_data.push_back(mem_wdata);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_wr(input int c, input int idx, input logic [DW-1:0] d);
    wr_en[c] = 1'b1;
    reg_addr[c*IW +: IW] = idx[IW-1:0];
    wr_data[c*DW +: DW]  = d;
  endtask

  task automatic quiet();
    wr_en = '0;
    op    = '0;
  endtask

  task automatic wait_idle(input int maxc);
    int n = 0;
    while (q.size() > 0 && n < maxc) begin
      tick();
      n++;
    end
    if (q.size() > 0) begin
      tests++;
      fails++;
      $display("FAIL wait_idle: burst still pending after %0d cycles", maxc);
    end
  endtask

  task automatic clear_log();
    log_addr.delete();
    log_data.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    mem_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();

    // Four entries per core, ops on the same edge as the final writes.
    clear_log();
    core_mask = 4'hF;
    base_addr = 16'h0100;
    for (int idx = 0; idx < 4; idx++) begin
      if (idx == 0) begin
        set_wr(0, 0, 16'hE007); set_wr(1, 0, 16'h0007);
        set_wr(2, 0, 16'hFFFF); set_wr(3, 0, 16'h8001);
      end else begin
        for (int c = 0; c < NCORES; c++) set_wr(c, idx, DW'($urandom));
      end
      if (idx == 3) op = 4'hF;
      tick();
    end
    quiet();
    wait_idle(50);
    check("t1_beats", log_addr.size(), 4);
    check("t1_beat0", log_data[0], 64'h8001_FFFF_0007_E007);
    for (int k = 0; k < 4; k++) check("t1_addr", log_addr[k], 16'h0100 + 16'(k));

    // Staggered ops with only cores 0 and 2 in the barrier.
    clear_log();
    core_mask = 4'h5;
    base_addr = 16'h0040;
    set_wr(0, 1, 16'h1111); set_wr(2, 2, 16'h2222); op = 4'b1000;
    tick();
    quiet(); op = 4'b0001;
    tick();
    op = 4'b0010;
    tick();
    op = 4'b0100;
    check("t2_before_op2", mem_wr, 0);
    tick();
    op = '0;
    check("t2_start", mem_wr, 1);
    wait_idle(50);
    check("t2_beats", log_addr.size(), 3);
    check("t2_beat1", log_data[1], 64'h0000_0000_0000_1111);
    check("t2_beat2", log_data[2], 64'h0000_2222_0000_0000);

    // Backpressure for three cycles on beat 1.
    clear_log();
    core_mask = 4'hF;
    base_addr = 16'h0200;
    for (int idx = 0; idx < 4; idx++) begin
      for (int c = 0; c < NCORES; c++) set_wr(c, idx, DW'($urandom));
      if (idx == 3) op = 4'hF;
      tick();
    end
    quiet();
    tick();
    mem_ready = 1'b0;
    repeat (3) tick();
    mem_ready = 1'b1;
    wait_idle(50);
    check("t3_beats", log_addr.size(), 4);
    for (int k = 0; k < 4; k++) check("t3_addr", log_addr[k], 16'h0200 + 16'(k));

    // Sparse write: only core 1 at index 5.
    clear_log();
    base_addr = 16'h0300;
    set_wr(1, 5, 16'hAAAA); op = 4'hF;
    tick();
    quiet();
    wait_idle(50);
    check("t4_beats", log_addr.size(), 6);
    check("t4_beat0", log_data[0], 64'h0);
    check("t4_beat5", log_data[5], 64'h0000_0000_AAAA_0000);

    // Address wrap.
    clear_log();
    base_addr = 16'hFFFE;
    set_wr(3, 3, 16'h5555); op = 4'hF;
    tick();
    quiet();
    wait_idle(50);
    check("t5_beats", log_addr.size(), 4);
    check("t5_addr0", log_addr[0], 16'hFFFE);
    check("t5_addr1", log_addr[1], 16'hFFFF);
    check("t5_addr2", log_addr[2], 16'h0000);
    check("t5_addr3", log_addr[3], 16'h0001);

    // Writes during a burst are rejected and never become visible.
    base_addr = 16'h0010;
    set_wr(0, 1, 16'h0BAD); op = 4'hF;
    tick();
    quiet();
    mem_ready = 1'b0;
    set_wr(0, 7, 16'hDEAD); set_wr(2, 9, 16'hBEEF);
    tick();
    quiet();
    check("t6_wr_err", wr_err, 4'b0101);
    tick();
    check("t6_wr_err_clr", wr_err, 4'b0000);
    mem_ready = 1'b1;
    wait_idle(50);
    tick();
    op = 4'hF;
    tick();
    op = '0;
    check("t6_empty_done", done, 1);
    check("t6_empty_no_wr", mem_wr, 0);
    tick();
    check("t6_done_pulse", done, 0);

    // Reset in the middle of a burst.
    set_wr(2, 2, 16'h7777); op = 4'hF;
    tick();
    quiet();
    mem_ready = 1'b0;
    tick();
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_mem_wr", mem_wr, 0);
    check("t6_rst_busy", busy, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    mem_ready = 1'b1;
    tick();
    op = 4'hF;
    tick();
    op = '0;
    check("t6_post_rst_empty", done, 1);
    check("t6_post_rst_no_wr", mem_wr, 0);
    tick();

    // Zero mask never completes, yet the ops stick for when the mask is set.
    core_mask = 4'h0;
    set_wr(0, 0, 16'h1234); op = 4'hF;
    tick();
    quiet();
    tick();
    check("mask0_no_burst", mem_wr, 0);
    check("mask0_no_done", done, 0);
    core_mask = 4'hF;
    tick();
    check("mask0_sticky_fire", mem_wr, 1);
    check("mask0_data", mem_wdata, 64'h0000_0000_0000_1234);
    wait_idle(50);

    // Random traffic.
    for (int n = 0; n < 400; n++) begin
      wr_en     = NCORES'($urandom);
      reg_addr  = (NCORES*IW)'($urandom);
      wr_data   = {$urandom, $urandom};
      op        = ($urandom_range(0, 5) == 0) ? NCORES'($urandom) : '0;
      if ($urandom_range(0, 15) == 0) core_mask = NCORES'($urandom);
      base_addr = AW'($urandom);
      mem_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    quiet();
    mem_ready = 1'b1;
    wait_idle(100);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
